// File: rtl/spio_serial_rx_pkg.sv
// Shared types and constants for the SPIO serial receiver.
// Holds the receive FSM encoding and the status register bit layout.
package spio_serial_rx_pkg;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_SHIFT    = 2'd1,
        RX_WAIT_PEN = 2'd2
    } rx_state_e;

    localparam int unsigned ST_VALID   = 0;
    localparam int unsigned ST_FRAME   = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_TMO     = 3;
    localparam int unsigned ST_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty flags and occupancy count.
// Push while full is accepted only when a pop happens on the same cycle.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(Depth));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spio_serial_rx.sv
// Deserialises the SPIO LED stream (clk/data/clear/latch) into parallel words,
// queues them in a FIFO and exposes data/status registers on the bus read path.
module spio_serial_rx
    import spio_serial_rx_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        s_clk,
    input  logic        s_dat,
    input  logic        s_clrn,
    input  logic        s_pen,
    input  logic        rd_en,
    input  logic        rd_sel,
    input  logic        clr_err,
    output logic [31:0] rd_data,
    output logic        rx_valid,
    output logic        irq
);

    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // Bit order in each synchroniser stage: {pen, clrn, dat, clk}.
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  sync_out;
    logic                        clk_prev_q, pen_prev_q;
    logic                        clk_rise_q, pen_rise_q, dat_q, clrn_q;

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_frame_q, err_ovf_q, err_tmo_q;
    logic             push, frame_set, tmo_set, ovf_set, pop;

    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [3:0]       cnt4;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            sync_q     <= '0;
            clk_prev_q <= 1'b0;
            pen_prev_q <= 1'b0;
            clk_rise_q <= 1'b0;
            pen_rise_q <= 1'b0;
            dat_q      <= 1'b0;
            clrn_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], {s_pen, s_clrn, s_dat, s_clk}};
            clk_prev_q <= sync_out[0];
            pen_prev_q <= sync_out[3];
            // Edge pulses are registered; data and clear are delayed to stay aligned.
            clk_rise_q <= sync_out[0] & ~clk_prev_q;
            pen_rise_q <= sync_out[3] & ~pen_prev_q;
            dat_q      <= sync_out[1];
            clrn_q     <= sync_out[2];
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        timer_d   = timer_q;
        push      = 1'b0;
        frame_set = 1'b0;
        tmo_set   = 1'b0;
        if (!clrn_q) begin
            state_d  = RX_IDLE;
            shreg_d  = '0;
            bitcnt_d = '0;
            timer_d  = '0;
        end else begin
            unique case (state_q)
                RX_IDLE: begin
                    timer_d = '0;
                    if (clk_rise_q) begin
                        shreg_d  = {shreg_q[WIDTH-2:0], dat_q};
                        bitcnt_d = BW'(1);
                        state_d  = RX_SHIFT;
                    end
                end
                RX_SHIFT: begin
                    timer_d = '0;
                    if (clk_rise_q) begin
                        shreg_d  = {shreg_q[WIDTH-2:0], dat_q};
                        bitcnt_d = bitcnt_q + BW'(1);
                        if (bitcnt_q == BW'(WIDTH - 1)) state_d = RX_WAIT_PEN;
                    end else if (pen_rise_q) begin
                        frame_set = 1'b1;
                        bitcnt_d  = '0;
                        state_d   = RX_IDLE;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        tmo_set  = 1'b1;
                        bitcnt_d = '0;
                        state_d  = RX_IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                RX_WAIT_PEN: begin
                    timer_d  = '0;
                    bitcnt_d = '0;
                    state_d  = RX_IDLE;
                    if (pen_rise_q) begin
                        push = 1'b1;
                    end else if (clk_rise_q) begin
                        frame_set = 1'b1;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        tmo_set = 1'b1;
                    end else begin
                        timer_d  = timer_q + TW'(1);
                        bitcnt_d = bitcnt_q;
                        state_d  = RX_WAIT_PEN;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign pop     = rd_en & ~rd_sel & ~fifo_empty;
    assign ovf_set = push & fifo_full & ~pop;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= RX_IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            timer_q     <= '0;
            err_frame_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            timer_q     <= timer_d;
            // A set on the same cycle as clr_err wins.
            err_frame_q <= (err_frame_q & ~clr_err) | frame_set;
            err_ovf_q   <= (err_ovf_q & ~clr_err) | ovf_set;
            err_tmo_q   <= (err_tmo_q & ~clr_err) | tmo_set;
        end
    end

    sync_fifo #(
        .Width (WIDTH),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (RSTN),
        .push_i  (push),
        .data_i  (shreg_q),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign cnt4     = 4'(fifo_count);
    assign rx_valid = ~fifo_empty;
    assign irq      = rx_valid | err_frame_q | err_ovf_q | err_tmo_q;

    always_comb begin
        rd_data = '0;
        if (rd_sel) begin
            rd_data[ST_VALID]          = rx_valid;
            rd_data[ST_FRAME]          = err_frame_q;
            rd_data[ST_OVF]            = err_ovf_q;
            rd_data[ST_TMO]            = err_tmo_q;
            rd_data[ST_CNT_LSB +: 4]   = cnt4;
        end else if (!fifo_empty) begin
            rd_data[WIDTH-1:0] = fifo_head;
        end
    end

endmodule

// File: tb/tb_spio_serial_rx.sv
// Directed bench for spio_serial_rx: serial frames driven at the pins,
// results checked through the bus data/status registers.
module tb_spio_serial_rx;

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic        s_clk = 1'b0, s_dat = 1'b0, s_clrn = 1'b1, s_pen = 1'b0;
    logic        rd_en = 1'b0, rd_sel = 1'b0, clr_err = 1'b0;
    logic [31:0] rd_data;
    logic        rx_valid, irq;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string       name;
        logic        sel;
        logic        pop;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    spio_serial_rx dut (
        .clk      (clk),
        .RSTN     (RSTN),
        .s_clk    (s_clk),
        .s_dat    (s_dat),
        .s_clrn   (s_clrn),
        .s_pen    (s_pen),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .clr_err  (clr_err),
        .rd_data  (rd_data),
        .rx_valid (rx_valid),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Sample the selected register, then optionally strobe a read.
    task automatic bus_read(input logic sel, input logic do_pop, output logic [31:0] val);
        rd_sel = sel;
        #1;
        val = rd_data;
        if (do_pop) begin
            rd_en = 1'b1;
            cyc(1);
            rd_en = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b);
        s_dat = b;
        cyc(4);
        s_clk = 1'b1;
        cyc(4);
        s_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(v[i]);
        cyc(4);
    endtask

    task automatic pulse_pen();
        s_pen = 1'b1;
        cyc(4);
        s_pen = 1'b0;
        cyc(6);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        cyc(1);
    endtask

    initial begin
        logic [31:0] v;
        int lat;

        vecs[0] = '{"ovf_status", 1'b1, 1'b0, 32'h0000_0045};
        vecs[1] = '{"ovf_data1",  1'b0, 1'b1, 32'h0000_0001};
        vecs[2] = '{"ovf_data2",  1'b0, 1'b1, 32'h0000_0002};
        vecs[3] = '{"ovf_data3",  1'b0, 1'b1, 32'h0000_0003};
        vecs[4] = '{"ovf_data4",  1'b0, 1'b1, 32'h0000_0004};
        vecs[5] = '{"ovf_empty",  1'b1, 1'b0, 32'h0000_0004};
        vecs[6] = '{"empty_rd",   1'b0, 1'b1, 32'h0000_0000};

        // Reset state
        cyc(3);
        bus_read(1'b1, 1'b0, v); check("rst_status", v, 32'h0);
        bus_read(1'b0, 1'b0, v); check("rst_data", v, 32'h0);
        check("rst_valid", {31'b0, rx_valid}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        RSTN = 1'b1;
        cyc(5);

        // Basic frame and latency
        send_bits(16'hA5C3, 16);
        s_pen = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            if (rx_valid && lat == 0) lat = k;
        end
        s_pen = 1'b0;
        cyc(4);
        check("latency", 32'(lat), 32'd4);
        bus_read(1'b1, 1'b0, v); check("f1_status", v, 32'h11);
        bus_read(1'b0, 1'b1, v); check("f1_data", v, 32'h0000_A5C3);
        check("f1_valid_drop", {31'b0, rx_valid}, 32'h0);

        // Short frame
        send_bits(16'h02AA, 10);
        pulse_pen();
        bus_read(1'b1, 1'b0, v); check("short_status", v, 32'h02);
        check("short_irq", {31'b0, irq}, 32'h1);
        pulse_clr();
        bus_read(1'b1, 1'b0, v); check("clr_status", v, 32'h00);
        check("clr_irq", {31'b0, irq}, 32'h0);

        // Overflow: five frames, no reads, then table-driven reads
        for (int f = 1; f <= 5; f++) begin
            send_bits(16'(f), 16);
            pulse_pen();
        end
        for (int i = 0; i < 7; i++) begin
            bus_read(vecs[i].sel, vecs[i].pop, v);
            check(vecs[i].name, v, vecs[i].exp);
        end
        pulse_clr();

        // Timeout then a clean frame
        send_bits(16'h0055, 7);
        cyc(1100);
        bus_read(1'b1, 1'b0, v); check("tmo_status", v, 32'h08);
        send_bits(16'hFFFF, 16);
        pulse_pen();
        bus_read(1'b1, 1'b0, v); check("tmo_next_status", v, 32'h19);
        bus_read(1'b0, 1'b1, v); check("tmo_next_data", v, 32'h0000_FFFF);
        pulse_clr();

        // Serial clear mid-frame
        send_bits(16'h00F0, 8);
        s_clrn = 1'b0;
        cyc(6);
        s_clrn = 1'b1;
        cyc(6);
        send_bits(16'h1234, 16);
        pulse_pen();
        bus_read(1'b1, 1'b0, v); check("clrn_status", v, 32'h11);
        bus_read(1'b0, 1'b1, v); check("clrn_data", v, 32'h0000_1234);
        bus_read(1'b1, 1'b0, v); check("clrn_after", v, 32'h00);

        // Reset during bit 9 with two words queued
        send_bits(16'h1111, 16);
        pulse_pen();
        send_bits(16'h2222, 16);
        pulse_pen();
        bus_read(1'b1, 1'b0, v); check("pre_rst_status", v, 32'h21);
        send_bits(16'h00C3, 8);
        s_dat = 1'b1;
        cyc(4);
        s_clk = 1'b1;
        cyc(2);
        RSTN = 1'b0;
        #1;
        check("arst_status", rd_data, 32'h0);
        check("arst_valid", {31'b0, rx_valid}, 32'h0);
        check("arst_irq", {31'b0, irq}, 32'h0);
        rd_sel = 1'b0;
        #1;
        check("arst_data", rd_data, 32'h0);
        s_clk = 1'b0;
        s_dat = 1'b0;
        cyc(3);
        RSTN = 1'b1;
        cyc(6);
        bus_read(1'b1, 1'b0, v); check("post_rst_status", v, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
